// File: rtl/ram2p_fifo_ctrl_if.sv
// Producer/consumer stream bundle for the RAM-backed FWFT FIFO controller.
interface ram2p_fifo_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 3
);
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [ADDR_W:0]   level;

    // Environment side: produces input words and consumes output words.
    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outData, level
    );

    // FIFO side.
    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outData, level
    );
endinterface

// File: rtl/ram2p_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of a 1-cycle-latency two-port RAM.
// Words live in the RAM, in a single in-flight read, or in a 2-entry output buffer.
module ram2p_fifo_ctrl #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 3
) (
    input  logic              clockCore,
    input  logic              resetCoreN,
    ram2p_fifo_ctrl_if.slave  s,
    output logic              ramEnableWrite,
    output logic [ADDR_W-1:0] ramAddressWrite,
    output logic [DATA_W-1:0] ramWriteData,
    output logic              ramEnableRead,
    output logic [ADDR_W-1:0] ramAddressRead,
    input  logic [DATA_W-1:0] ramReadData
);
    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [CW-1:0]     r_memCount;
    logic [CW-1:0]     r_level;
    logic              r_readPending;
    logic [1:0]        r_bufCount;
    logic [DATA_W-1:0] r_bufHead;
    logic [DATA_W-1:0] r_bufTail;
    logic              r_inReady;
    logic              r_outValid;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [1:0]        w_afterPop;
    logic [1:0]        w_bufCountNext;
    logic [CW-1:0]     w_levelNext;
    logic [CW-1:0]     w_memCountNext;
    logic [DATA_W-1:0] w_headNext;
    logic [DATA_W-1:0] w_tailNext;

    // Handshakes and the read-issue decision: issue only if the buffer can take the
    // returning word once the current in-flight read and this cycle's pop are counted.
    always_comb begin
        w_push         = s.inValid & r_inReady;
        w_pop          = r_outValid & s.outReady;
        w_occ          = 3'(r_bufCount) + 3'(r_readPending) - 3'(w_pop);
        w_issue        = (r_memCount != '0) && (w_occ < 3'd2);
        w_afterPop     = r_bufCount - 2'(w_pop);
        w_bufCountNext = w_afterPop + 2'(r_readPending);
        w_levelNext    = r_level + CW'(w_push) - CW'(w_pop);
        w_memCountNext = r_memCount + CW'(w_push) - CW'(w_issue);
    end

    // Output buffer: head is the visible word; the returning RAM word lands at the tail.
    always_comb begin
        w_headNext = r_bufHead;
        w_tailNext = r_bufTail;
        if (w_pop && (r_bufCount == 2'd2)) begin
            w_headNext = r_bufTail;
        end
        if (r_readPending) begin
            if (w_afterPop == 2'd0) begin
                w_headNext = ramReadData;
            end else begin
                w_tailNext = ramReadData;
            end
        end
    end

    // RAM port drive; write address is the committed write pointer.
    always_comb begin
        ramEnableWrite  = w_push;
        ramAddressWrite = r_wrPtr;
        ramWriteData    = s.inData;
        ramEnableRead   = w_issue;
        ramAddressRead  = r_rdPtr;
    end

    // State and registered stream outputs.
    always_ff @(posedge clockCore or negedge resetCoreN) begin
        if (!resetCoreN) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_memCount    <= '0;
            r_level       <= '0;
            r_readPending <= 1'b0;
            r_bufCount    <= 2'd0;
            r_bufHead     <= '0;
            r_bufTail     <= '0;
            r_inReady     <= 1'b0;
            r_outValid    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            r_memCount    <= w_memCountNext;
            r_level       <= w_levelNext;
            r_readPending <= w_issue;
            r_bufCount    <= w_bufCountNext;
            r_bufHead     <= w_headNext;
            r_bufTail     <= w_tailNext;
            r_inReady     <= (w_levelNext < C_DEPTH);
            r_outValid    <= (w_bufCountNext != 2'd0);
        end
    end

    assign s.inReady  = r_inReady;
    assign s.outValid = r_outValid;
    assign s.outData  = r_bufHead;
    assign s.level    = r_level;

endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// Directed bench for ram2p_fifo_ctrl with a behavioural 256x3 RAM and a scoreboard queue.
module tb_ram2p_fifo_ctrl;
    logic       clk = 1'b0;
    logic       resetCoreN = 1'b1;
    logic       ramEnableWrite;
    logic [7:0] ramAddressWrite;
    logic [2:0] ramWriteData;
    logic       ramEnableRead;
    logic [7:0] ramAddressRead;
    logic [2:0] ramReadData;
    logic [2:0] ram_mem [256];

    int         errors = 0;
    int         checks = 0;
    logic [2:0] q[$];
    int         m_level = 0;
    logic [7:0] m_wr = 8'd0;
    logic       m_inrdy = 1'b0;
    int         n_push = 0;
    int         n_pop = 0;
    int         pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    ram2p_fifo_ctrl_if bus ();

    ram2p_fifo_ctrl dut (
        .clockCore       (clk),
        .resetCoreN      (resetCoreN),
        .s               (bus.slave),
        .ramEnableWrite  (ramEnableWrite),
        .ramAddressWrite (ramAddressWrite),
        .ramWriteData    (ramWriteData),
        .ramEnableRead   (ramEnableRead),
        .ramAddressRead  (ramAddressRead),
        .ramReadData     (ramReadData)
    );

    always #5 clk = ~clk;

    // Two-port RAM with registered read data.
    always @(posedge clk) begin
        if (ramEnableWrite) ram_mem[ramAddressWrite] <= ramWriteData;
        if (ramEnableRead)  ramReadData <= ram_mem[ramAddressRead];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic iv, input logic [2:0] d, input logic ordy);
        logic push;
        logic pop;
        logic [2:0] exp;
        bus.inValid  = iv;
        bus.inData   = d;
        bus.outReady = ordy;
        #1;
        push = bus.inValid & bus.inReady;
        pop  = bus.outValid & bus.outReady;
        chk("level", 32'(bus.level), 32'(m_level));
        chk("inReady", 32'(bus.inReady), 32'(m_inrdy));
        chk("ramEnableWrite", 32'(ramEnableWrite), 32'(push));
        chk("bufCount_max", 32'(dut.r_bufCount <= 2'd2), 32'd1);
        if (push) begin
            chk("ramAddressWrite", 32'(ramAddressWrite), 32'(m_wr));
            chk("ramWriteData", 32'(ramWriteData), 32'(d));
            q.push_back(d);
            m_wr = m_wr + 8'd1;
            n_push++;
        end
        if (ramEnableRead && ramEnableWrite)
            chk("rw_addr_conflict", 32'(ramAddressRead != ramAddressWrite), 32'd1);
        if (pop) begin
            chk("pop_has_word", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp = q.pop_front();
                chk("outData", 32'(bus.outData), 32'(exp));
            end
            n_pop++;
        end
        m_level = m_level + int'(push) - int'(pop);
        m_inrdy = (m_level < 256);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetCoreN   = 1'b0;
        bus.inValid  = 1'b0;
        bus.inData   = 3'd0;
        bus.outReady = 1'b0;
        #1;
        chk("rst_inReady", 32'(bus.inReady), 32'd0);
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_outData", 32'(bus.outData), 32'd0);
        q.delete();
        m_level = 0;
        m_wr    = 8'd0;
        m_inrdy = 1'b0;
        @(negedge clk);
        resetCoreN = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && m_level != 0; i++) step(1'b0, 3'd0, 1'b1);
        chk(tag, 32'(bus.level), 32'd0);
        chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 8 && !bus.outValid; n++) step(1'b0, 3'd0, 1'b0);
        chk(tag, 32'(bus.outValid), 32'd1);
    endtask

    initial begin
        int p0;
        int c0;
        bus.inValid  = 1'b0;
        bus.inData   = 3'd0;
        bus.outReady = 1'b0;
        #2;
        do_reset();

        // Single word: write at T, read at T+1, visible at T+3.
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'b101, 1'b1);
        chk("t2_rd_en", 32'(ramEnableRead), 32'd1);
        chk("t2_rd_addr", 32'(ramAddressRead), 32'd0);
        step(1'b0, 3'd0, 1'b1);
        chk("t2_valid_T2", 32'(bus.outValid), 32'd0);
        step(1'b0, 3'd0, 1'b1);
        chk("t2_valid_T3", 32'(bus.outValid), 32'd1);
        chk("t2_data_T3", 32'(bus.outData), 32'b101);
        chk("t2_level_T3", 32'(bus.level), 32'd1);
        step(1'b0, 3'd0, 1'b1);
        chk("t2_level_after_pop", 32'(bus.level), 32'd0);
        chk("t2_valid_after_pop", 32'(bus.outValid), 32'd0);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < 256; i++) step(1'b1, 3'(i), 1'b0);
        chk("t3_level_full", 32'(bus.level), 32'd256);
        chk("t3_inReady_full", 32'(bus.inReady), 32'd0);
        p0 = n_push;
        step(1'b1, 3'd7, 1'b0);
        chk("t3_no_257th", 32'(n_push - p0), 32'd0);
        step(1'b0, 3'd0, 1'b1);
        chk("t3_inReady_after_pop", 32'(bus.inReady), 32'd1);
        drain("t3_drain");

        // Sustained stream: one word per cycle after a 3-cycle fill.
        p0 = n_push;
        c0 = n_pop;
        for (int i = 0; i < 600; i++) step(1'b1, 3'(i % 8), 1'b1);
        chk("t4_pushes", 32'(n_push - p0), 32'd600);
        chk("t4_pops", 32'(n_pop - c0), 32'd597);
        drain("t4_drain");

        // Irregular consumer.
        p0 = n_push;
        c0 = n_pop;
        for (int k = 0; k < 800 && (n_push - p0) < 64; k++)
            step(1'b1, 3'($urandom_range(0, 7)), 1'(pat[k % 8]));
        chk("t5_pushes", 32'(n_push - p0), 32'd64);
        for (int k = 0; k < 800 && m_level != 0; k++)
            step(1'b0, 3'd0, 1'(pat[k % 8]));
        chk("t5_pops", 32'(n_pop - c0), 32'd64);
        chk("t5_level", 32'(bus.level), 32'd0);

        // Empty FIFO: push with outReady=1 must not pop; then push+pop holds level.
        chk("t6_empty_valid", 32'(bus.outValid), 32'd0);
        step(1'b1, 3'd6, 1'b1);
        chk("t6_level_one", 32'(bus.level), 32'd1);
        wait_valid("t6_first_valid");
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'(k + 1), 1'b1);
            chk("t6_level_hold", 32'(bus.level), 32'd1);
            wait_valid("t6_refill_valid");
        end
        drain("t6_drain");

        // Reset in the middle of a stream at level 100.
        for (int i = 0; i < 100; i++) step(1'b1, 3'(i), 1'b0);
        chk("t1_level_100", 32'(bus.level), 32'd100);
        do_reset();
        step(1'b0, 3'd0, 1'b1);
        chk("t1_inReady_1cyc", 32'(bus.inReady), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("t1_no_stale", 32'(bus.outValid), 32'd0);
            step(1'b0, 3'd0, 1'b1);
        end
        step(1'b1, 3'd3, 1'b1);
        drain("t1_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
